matrix_stream_reader: RTL and testbench

//  Read-side sequencer for the matrix memory: on start, scans a rows x cols sub-matrix
//  and streams every element out over a valid/ready interface, with element indices.

---
 rtl/matrix_stream_reader.sv | 246 ++++++++++++++++++++++++
 tb/tb_matrix_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_reader.sv
// matrix_stream_reader
//   Read-side sequencer for the matrix memory. A start request latches a
//   rows x cols sub-matrix size and scan order. The block then walks the
//   element addresses, row-major or column-major when transpose=1, on
//   rd_x/rd_y. It absorbs the memory's 1-cycle read latency and streams
//   each element, with its row/col indices, out of a 2-entry output
//   buffer on a valid/ready interface.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             1-cycle scan request, only honoured in IDLE
//   rows, cols        sub-matrix size 0..2^L, latched on an accepted start
//   transpose         0 = row-major, 1 = column-major, latched on start
//   busy              scan in progress (RUN or DRAIN)
//   done              1-cycle pulse once the final beat has been accepted
//   rd_x, rd_y        memory read address (row, column)
//   rd_data           memory read data, valid the cycle after the address
//   m_data            element value
//   m_row, m_col      element indices
//   m_last            final element of the scan
//   m_valid, m_ready  stream handshake
module matrix_stream_reader #(
    parameter int maxWidthLen = 3,
    parameter int sizeValue   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [maxWidthLen:0]   rows,
    input  logic [maxWidthLen:0]   cols,
    input  logic                   transpose,
    output logic                   busy,
    output logic                   done,
    output logic [maxWidthLen-1:0] rd_x,
    output logic [maxWidthLen-1:0] rd_y,
    input  logic [sizeValue-1:0]   rd_data,
    output logic [sizeValue-1:0]   m_data,
    output logic [maxWidthLen-1:0] m_row,
    output logic [maxWidthLen-1:0] m_col,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready
);

    localparam int L = maxWidthLen;
    localparam int W = sizeValue;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Address counters; these drive rd_x/rd_y directly.
    logic [L-1:0] row_q, row_d;
    logic [L-1:0] col_q, col_d;
    logic [L-1:0] rows_m1_q, rows_m1_d;
    logic [L-1:0] cols_m1_q, cols_m1_d;
    logic         trans_q, trans_d;

    // Tag for the read currently inside the memory's 1-cycle latency.
    logic         infl_q, infl_d;
    logic [L-1:0] tag_row_q, tag_row_d;
    logic [L-1:0] tag_col_q, tag_col_d;
    logic         tag_last_q, tag_last_d;

    // 2-entry output FIFO.
    logic [W-1:0] fifo_data_q [0:1];
    logic [W-1:0] fifo_data_d [0:1];
    logic [L-1:0] fifo_row_q  [0:1];
    logic [L-1:0] fifo_row_d  [0:1];
    logic [L-1:0] fifo_col_q  [0:1];
    logic [L-1:0] fifo_col_d  [0:1];
    logic         fifo_last_q [0:1];
    logic         fifo_last_d [0:1];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    logic         push;
    logic         pop;
    logic         issue;
    logic         is_last;
    logic [2:0]   occ;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rows_m1_d   = rows_m1_q;
        cols_m1_d   = cols_m1_q;
        trans_d     = trans_q;
        infl_d      = 1'b0;
        tag_row_d   = tag_row_q;
        tag_col_d   = tag_col_q;
        tag_last_d  = tag_last_q;
        fifo_data_d = fifo_data_q;
        fifo_row_d  = fifo_row_q;
        fifo_col_d  = fifo_col_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        push    = infl_q;
        pop     = (count_q != 2'd0) && m_ready;
        is_last = (row_q == rows_m1_q) && (col_q == cols_m1_q);

        // Occupancy after this edge would be count + inflight - pop. It must
        // stay below 2 so that the read issued now always has a free slot
        // when its data returns next cycle.
        occ   = {1'b0, count_q} + {2'b00, infl_q};
        issue = (state_q == S_RUN) && (pop ? (occ < 3'd3) : (occ < 3'd2));

        if (issue) begin
            infl_d     = 1'b1;
            tag_row_d  = row_q;
            tag_col_d  = col_q;
            tag_last_d = is_last;
            if (!is_last) begin
                if (!trans_q) begin
                    if (col_q == cols_m1_q) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    if (row_q == rows_m1_q) begin
                        row_d = '0;
                        col_d = col_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
        end

        if (push) begin
            fifo_data_d[wr_ptr_q] = rd_data;
            fifo_row_d[wr_ptr_q]  = tag_row_q;
            fifo_col_d[wr_ptr_q]  = tag_col_q;
            fifo_last_d[wr_ptr_q] = tag_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((rows == '0) || (cols == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        row_d     = '0;
                        col_d     = '0;
                        // A size of 2^L has zero low bits, so the decrement
                        // wraps to the all-ones maximum index as intended.
                        rows_m1_d = rows[L-1:0] - 1'b1;
                        cols_m1_d = cols[L-1:0] - 1'b1;
                        trans_d   = transpose;
                    end
                end
            end
            S_RUN: begin
                if (issue && is_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finish on the edge that accepts the final beat.
                if (!infl_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rows_m1_q   <= '0;
            cols_m1_q   <= '0;
            trans_q     <= 1'b0;
            infl_q      <= 1'b0;
            tag_row_q   <= '0;
            tag_col_q   <= '0;
            tag_last_q  <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_row_q  <= '{default: '0};
            fifo_col_q  <= '{default: '0};
            fifo_last_q <= '{default: 1'b0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rows_m1_q   <= rows_m1_d;
            cols_m1_q   <= cols_m1_d;
            trans_q     <= trans_d;
            infl_q      <= infl_d;
            tag_row_q   <= tag_row_d;
            tag_col_q   <= tag_col_d;
            tag_last_q  <= tag_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_row_q  <= fifo_row_d;
            fifo_col_q  <= fifo_col_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign rd_x    = row_q;
    assign rd_y    = col_q;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = fifo_data_q[rd_ptr_q];
    assign m_row   = fifo_row_q[rd_ptr_q];
    assign m_col   = fifo_col_q[rd_ptr_q];
    // A stale slot can hold a last flag, so gate it with valid.
    assign m_last  = m_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Testbench for matrix_stream_reader with a 4x4 memory holding mem[{x,y}] = 4x+y.
module tb_matrix_stream_reader;

    localparam int L = 2;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [L:0]   rows;
    logic [L:0]   cols;
    logic         transpose;
    logic         busy;
    logic         done;
    logic [L-1:0] rd_x;
    logic [L-1:0] rd_y;
    logic [W-1:0] rd_data;
    logic [W-1:0] m_data;
    logic [L-1:0] m_row;
    logic [L-1:0] m_col;
    logic         m_last;
    logic         m_valid;
    logic         m_ready;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] bd [$];
    logic [L-1:0] br [$];
    logic [L-1:0] bc [$];
    logic         bl [$];
    int           bcyc [$];
    int           first_valid;
    int           done_cyc;
    int           done_cnt;
    bit           busy_seen;

    matrix_stream_reader #(
        .maxWidthLen(L),
        .sizeValue  (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rows     (rows),
        .cols     (cols),
        .transpose(transpose),
        .busy     (busy),
        .done     (done),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_data  (rd_data),
        .m_data   (m_data),
        .m_row    (m_row),
        .m_col    (m_col),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    // Synchronous memory, one cycle of read latency: {x,y} as a number is 4x+y.
    always @(posedge clk) rd_data <= {{(W-2*L){1'b0}}, rd_x, rd_y};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one scan from a start pulse. Cycle n=1 is the cycle after start.
    // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0 repeating.
    // restart_at: cycle at which start is re-pulsed with other sizes (-1 = never).
    // abort_at: return as soon as this many beats have been accepted (-1 = never).
    task automatic scan(input int r, input int c, input bit tr, input int mode,
                        input int restart_at, input int abort_at);
        int          n;
        bit          held_pending;
        logic [21:0] held;
        bd.delete(); br.delete(); bc.delete(); bl.delete(); bcyc.delete();
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        busy_seen   = 1'b0;
        held_pending = 1'b0;
        held         = '0;
        rows      = r[L:0];
        cols      = c[L:0];
        transpose = tr;
        m_ready   = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (n < 300) begin
            start = (n == restart_at);
            if (n == restart_at) begin
                rows      = 3'd1;
                cols      = 3'd1;
                transpose = ~tr;
            end
            m_ready = (mode == 0) ? 1'b1 : ((n % 3) == 1);
            if (held_pending) begin
                check($sformatf("stall_hold_c%0d", n), {m_valid, m_data, m_row, m_col, m_last}, held);
                held_pending = 1'b0;
            end
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (m_valid && first_valid < 0) first_valid = n;
            if (m_valid && m_ready) begin
                bd.push_back(m_data);
                br.push_back(m_row);
                bc.push_back(m_col);
                bl.push_back(m_last);
                bcyc.push_back(n);
                if (bd.size() == abort_at) break;
            end else if (m_valid) begin
                held = {m_valid, m_data, m_row, m_col, m_last};
                held_pending = 1'b1;
            end
            if (done_cyc >= 0 && n >= done_cyc + 3) break;
            tick();
            n++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
    endtask

    // Compares the logged beats with the scan order worked out independently.
    // base >= 0 also requires beat i to be accepted in cycle base+i.
    task automatic verify(input string name, input int r, input int c, input bit tr, input int base);
        int total;
        total = r * c;
        check({name, "_count"}, bd.size(), total);
        for (int i = 0; i < total; i++) begin
            if (i < bd.size()) begin
                int er;
                int ec;
                logic [W-1:0] ed;
                logic [L-1:0] erl;
                logic [L-1:0] ecl;
                logic         el;
                if (!tr) begin
                    er = i / c;
                    ec = i % c;
                end else begin
                    ec = i / r;
                    er = i % r;
                end
                ed  = W'(er * 4 + ec);
                erl = L'(er);
                ecl = L'(ec);
                el  = (i == total - 1);
                check($sformatf("%s_beat%0d", name, i), {bd[i], br[i], bc[i], bl[i]}, {ed, erl, ecl, el});
                if (base >= 0) check($sformatf("%s_cyc%0d", name, i), bcyc[i], base + i);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rows = '0; cols = '0; transpose = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        check("reset_flags", {busy, done, m_valid, m_last}, 4'b0000);
        check("reset_mdata", {m_data, m_row, m_col}, '0);
        check("reset_addr", {rd_x, rd_y}, '0);
        rst = 1'b0;
        tick();

        // T1: 4x4 row-major, full throughput
        scan(4, 4, 1'b0, 0, -1, -1);
        check("T1_first_valid", first_valid, 3);
        check("T1_done_cyc", done_cyc, 19);
        check("T1_done_cnt", done_cnt, 1);
        check("T1_busy_seen", {31'd0, busy_seen}, 1);
        verify("T1", 4, 4, 1'b0, 3);

        // T2: 2x3 column-major
        scan(2, 3, 1'b1, 0, -1, -1);
        check("T2_done_cyc", done_cyc, 9);
        check("T2_done_cnt", done_cnt, 1);
        verify("T2", 2, 3, 1'b1, 3);

        // T3: back-pressure with m_ready 1,0,0,...
        scan(4, 4, 1'b0, 1, -1, -1);
        check("T3_done_cnt", done_cnt, 1);
        verify("T3", 4, 4, 1'b0, -1);

        // T4: empty sub-matrix
        scan(0, 4, 1'b0, 0, -1, -1);
        check("T4_done_cyc", done_cyc, 1);
        check("T4_done_cnt", done_cnt, 1);
        check("T4_first_valid", first_valid, -1);
        check("T4_busy_seen", {31'd0, busy_seen}, 0);
        check("T4_beats", bd.size(), 0);

        // T5: async reset after beat 5, then a clean rescan
        scan(4, 4, 1'b0, 0, -1, 5);
        check("T5_beats_before_rst", bd.size(), 5);
        tick();
        check("T5_valid_pre_rst", {31'd0, m_valid}, 1);
        rst = 1'b1;
        #1;
        check("T5_rst_outputs", {busy, done, m_valid, m_last}, 4'b0000);
        tick();
        check("T5_rst_hold", {busy, done, m_valid}, 3'b000);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("T5_post_rst%0d", k), {busy, done, m_valid}, 3'b000);
        end
        scan(4, 4, 1'b0, 0, -1, -1);
        check("T5_rescan_done_cyc", done_cyc, 19);
        check("T5_rescan_done_cnt", done_cnt, 1);
        verify("T5r", 4, 4, 1'b0, 3);

        // T6: start re-pulsed with different sizes during RUN
        scan(4, 4, 1'b0, 0, 5, -1);
        check("T6_done_cyc", done_cyc, 19);
        check("T6_done_cnt", done_cnt, 1);
        verify("T6", 4, 4, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
